// File: rtl/mem_bus_controller.sv
// -----------------------------------------------------------------------------
// mem_bus_controller
//
// Main-memory model sitting directly behind the core's memory bus. Tagged
// line read/write requests are queued in order, each is served against an
// on-chip line array after LATENCY cycles, and a one-cycle tagged response
// is returned to the requester.
//
// Ports:
//   clock      - system clock, all state changes on the rising edge
//   reset      - asynchronous active-low reset
//   req_read   - read line request
//   req_write  - write line request (wins over req_read)
//   req_id     - requester tag (0 = dcache, 1 = icache)
//   req_addr   - byte address, line offset bits ignored
//   req_data   - write line data
//   req_ready  - queue can accept a request this cycle
//   resp_valid - one-cycle response pulse
//   resp_id    - tag of the completed request
//   resp_addr  - line-aligned address of the completed request
//   resp_data  - read data, or echo of the written data
//   busy       - queue non-empty or an operation in flight
// -----------------------------------------------------------------------------
module mem_bus_controller #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int ID_WIDTH    = 1,
    parameter int MEM_LINES   = 1024,
    parameter int LATENCY     = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [ID_WIDTH-1:0]   req_id,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_data,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [ID_WIDTH-1:0]   resp_id,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [LINE_WIDTH-1:0] resp_data,
    output logic                  busy
);

    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [PTR_W:0]   Q_FULL   = (PTR_W + 1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    // ---------------------------------------------------------------- queue
    logic                  q_write_reg [QUEUE_DEPTH];
    logic [ID_WIDTH-1:0]   q_id_reg    [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_addr_reg  [QUEUE_DEPTH];
    logic [LINE_WIDTH-1:0] q_data_reg  [QUEUE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [PTR_W:0]        count_reg;

    logic                  q_full;
    logic                  q_empty;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] req_addr_line;

    // Offset bits are dropped on entry so the queue, the index and the
    // response all carry the line-aligned address.
    for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_addr_align
        if (gi < OFF_W) begin : g_off
            assign req_addr_line[gi] = 1'b0;
        end else begin : g_keep
            assign req_addr_line[gi] = req_addr[gi];
        end
    end

    logic unused_offset_bits;
    assign unused_offset_bits = ^req_addr;

    // Full is taken from the registered count only, so a dequeue in the same
    // cycle never opens a slot for an enqueue.
    assign q_full    = (count_reg == Q_FULL);
    assign q_empty   = (count_reg == '0);
    assign req_ready = ~q_full;
    assign push      = (req_read | req_write) & ~q_full;

    always_ff @(posedge clock) begin
        if (push) begin
            q_write_reg[wr_ptr_reg] <= req_write;
            q_id_reg[wr_ptr_reg]    <= req_id;
            q_addr_reg[wr_ptr_reg]  <= req_addr_line;
            q_data_reg[wr_ptr_reg]  <= req_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------ FSM
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             access;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        access     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!q_empty) begin
                    pop        = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    access     = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                // Chaining straight into BUSY keeps queued requests at one
                // completion every LATENCY+1 cycles.
                if (!q_empty) begin
                    pop        = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = ST_BUSY;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------- operation register
    logic                  op_write_reg;
    logic [ID_WIDTH-1:0]   op_id_reg;
    logic [ADDR_WIDTH-1:0] op_addr_reg;
    logic [LINE_WIDTH-1:0] op_data_reg;
    logic [IDX_W-1:0]      op_idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_write_reg <= 1'b0;
            op_id_reg    <= '0;
            op_addr_reg  <= '0;
            op_data_reg  <= '0;
        end else if (pop) begin
            op_write_reg <= q_write_reg[rd_ptr_reg];
            op_id_reg    <= q_id_reg[rd_ptr_reg];
            op_addr_reg  <= q_addr_reg[rd_ptr_reg];
            op_data_reg  <= q_data_reg[rd_ptr_reg];
        end
    end

    // Upper address bits are ignored so out-of-range addresses wrap.
    assign op_idx = op_addr_reg[OFF_W +: IDX_W];

    // ------------------------------------------------------- line storage
    // Contents are deliberately left out of reset so they survive it.
    logic [LINE_WIDTH-1:0] mem [MEM_LINES];

    always_ff @(posedge clock) begin
        if (access && op_write_reg) begin
            mem[op_idx] <= op_data_reg;
        end
    end

    // ------------------------------------------------------------ response
    logic                  resp_valid_reg;
    logic [ID_WIDTH-1:0]   resp_id_reg;
    logic [ADDR_WIDTH-1:0] resp_addr_reg;
    logic [LINE_WIDTH-1:0] resp_data_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= '0;
            resp_addr_reg  <= '0;
            resp_data_reg  <= '0;
        end else begin
            resp_valid_reg <= access;
            if (access) begin
                resp_id_reg   <= op_id_reg;
                resp_addr_reg <= op_addr_reg;
                // A write echoes its own data rather than reading back.
                resp_data_reg <= op_write_reg ? op_data_reg : mem[op_idx];
            end
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_id    = resp_id_reg;
    assign resp_addr  = resp_addr_reg;
    assign resp_data  = resp_data_reg;
    assign busy       = ~q_empty | (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_controller.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_controller
//
// Directed bench for mem_bus_controller with default parameters
// (LINE_WIDTH=128, MEM_LINES=1024, LATENCY=4, QUEUE_DEPTH=4).
// A table of single-request vectors is applied in a loop; hand-written
// sequences cover exact latency, back-to-back ordering, queue full and
// reset during an operation.
// -----------------------------------------------------------------------------
module tb_mem_bus_controller;

    logic         clock;
    logic         reset;
    logic         req_read;
    logic         req_write;
    logic [0:0]   req_id;
    logic [31:0]  req_addr;
    logic [127:0] req_data;
    logic         req_ready;
    logic         resp_valid;
    logic [0:0]   resp_id;
    logic [31:0]  resp_addr;
    logic [127:0] resp_data;
    logic         busy;

    mem_bus_controller dut (
        .clock      (clock),
        .reset      (reset),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_id     (req_id),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_addr  (resp_addr),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [127:0] D_A5 = {16{8'hA5}};
    localparam logic [127:0] D_FF = 128'hFF;
    localparam logic [127:0] D_1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D_3  = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;

    typedef struct {
        int           t;
        logic [0:0]   id;
        logic [31:0]  addr;
        logic [127:0] data;
    } resp_t;

    typedef struct {
        string        name;
        logic         rd;
        logic         wr;
        logic [0:0]   id;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [0:0]   exp_id;
        logic [31:0]  exp_addr;
        logic [127:0] exp_data;
    } vec_t;

    int    n_cmp;
    int    n_fail;
    int    cyc;
    resp_t rq[$];
    vec_t  vecs[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it and any response
    // pulse is logged with the edge number.
    task automatic tick();
        resp_t r;
        @(posedge clock);
        #1;
        cyc++;
        if (resp_valid) begin
            r.t    = cyc;
            r.id   = resp_id;
            r.addr = resp_addr;
            r.data = resp_data;
            rq.push_back(r);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [0:0] id,
                         input logic [31:0] addr, input logic [127:0] data);
        req_read  = rd;
        req_write = wr;
        req_id    = id;
        req_addr  = addr;
        req_data  = data;
    endtask

    task automatic idle_bus();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 128'h0);
    endtask

    task automatic wait_resps(input int n, input int budget);
        int k;
        k = 0;
        while (rq.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    // One request into an idle controller; checks latency and response fields.
    task automatic single(input string name, input logic rd, input logic wr, input logic [0:0] id,
                          input logic [31:0] addr, input logic [127:0] data,
                          input logic [0:0] exp_id, input logic [31:0] exp_addr,
                          input logic [127:0] exp_data);
        int t0;
        rq.delete();
        drive(rd, wr, id, addr, data);
        tick();
        t0 = cyc;
        idle_bus();
        wait_resps(1, 20);
        check({name, "_got_resp"}, 128'(rq.size()), 128'(1));
        if (rq.size() >= 1) begin
            check({name, "_latency"}, 128'(rq[0].t - t0), 128'(5));
            check({name, "_id"},   128'(rq[0].id),   128'(exp_id));
            check({name, "_addr"}, 128'(rq[0].addr), 128'(exp_addr));
            check({name, "_data"}, rq[0].data, exp_data);
            $display("txn %s rd=%0b wr=%0b id=%0d addr=%h -> resp id=%0d addr=%h data=%h",
                     name, rd, wr, id, addr, rq[0].id, rq[0].addr, rq[0].data);
        end
        tick();
        tick();
    endtask

    initial begin
        int t0;
        int t_acc;
        int k;

        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        reset  = 1'b0;
        idle_bus();

        vecs[0] = '{"rdwr_both",    1'b1, 1'b1, 1'b0, 32'h0000_0080, D_FF,   1'b0, 32'h0000_0080, D_FF};
        vecs[1] = '{"rd_line8_off", 1'b1, 1'b0, 1'b1, 32'h0000_008F, 128'h0, 1'b1, 32'h0000_0080, D_FF};
        vecs[2] = '{"wr_alias",     1'b0, 1'b1, 1'b0, 32'h0000_4010, D_1,    1'b0, 32'h0000_4010, D_1};
        vecs[3] = '{"rd_alias",     1'b1, 1'b0, 1'b1, 32'h0000_0010, 128'h0, 1'b1, 32'h0000_0010, D_1};
        vecs[4] = '{"wr_line3",     1'b0, 1'b1, 1'b1, 32'h0000_0030, D_3,    1'b1, 32'h0000_0030, D_3};
        vecs[5] = '{"rd_line3",     1'b1, 1'b0, 1'b0, 32'h0000_003C, 128'h0, 1'b0, 32'h0000_0030, D_3};
        vecs[6] = '{"rd_preload",   1'b1, 1'b0, 1'b1, 32'h0000_0104, 128'h0, 1'b1, 32'h0000_0100, D_A5};

        // ---- reset state
        #2;
        check("rst_resp_valid", 128'(resp_valid), 128'(0));
        check("rst_resp_id",    128'(resp_id),    128'(0));
        check("rst_resp_addr",  128'(resp_addr),  128'(0));
        check("rst_resp_data",  resp_data,        128'h0);
        check("rst_busy",       128'(busy),       128'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_req_ready", 128'(req_ready), 128'(1));

        // ---- preload line 0x10 with A5 pattern (id 0 write)
        single("preload_wr", 1'b0, 1'b1, 1'b0, 32'h100, D_A5, 1'b0, 32'h100, D_A5);

        // ---- exact latency of a single read: pulse only after edge 5
        rq.delete();
        drive(1'b1, 1'b0, 1'b1, 32'h100, 128'h0);
        tick();
        t0 = cyc;
        idle_bus();
        for (int i = 0; i < 6; i++) tick();
        check("lat_pulse_count", 128'(rq.size()), 128'(1));
        if (rq.size() >= 1) begin
            check("lat_edge", 128'(rq[0].t - t0), 128'(5));
            check("lat_id",   128'(rq[0].id),     128'(1));
            check("lat_addr", 128'(rq[0].addr),   128'(32'h100));
            check("lat_data", rq[0].data, D_A5);
            $display("txn latency_read id=1 addr=00000100 -> resp at edge +%0d data=%h",
                     rq[0].t - t0, rq[0].data);
        end
        check("lat_pulse_ended", 128'(resp_valid), 128'(0));
        check("lat_hold_data",   resp_data, D_A5);
        tick();

        // ---- table-driven single transactions
        for (int i = 0; i < 7; i++) begin
            single(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].id, vecs[i].addr,
                   vecs[i].data, vecs[i].exp_id, vecs[i].exp_addr, vecs[i].exp_data);
        end

        // ---- write then read same line on consecutive edges
        rq.delete();
        drive(1'b0, 1'b1, 1'b0, 32'h40, 128'h1234);
        tick();
        t0 = cyc;
        drive(1'b1, 1'b0, 1'b1, 32'h4C, 128'h0);
        tick();
        idle_bus();
        wait_resps(2, 30);
        check("wr_rd_count", 128'(rq.size()), 128'(2));
        if (rq.size() >= 2) begin
            check("wr_rd_first_edge", 128'(rq[0].t - t0),       128'(5));
            check("wr_rd_spacing",    128'(rq[1].t - rq[0].t),  128'(5));
            check("wr_rd_first_data", rq[0].data, 128'h1234);
            check("wr_rd_second_id",   128'(rq[1].id),   128'(1));
            check("wr_rd_second_addr", 128'(rq[1].addr), 128'(32'h40));
            check("wr_rd_second_data", rq[1].data, 128'h1234);
            $display("txn write_then_read resp0 t=%0d data=%h resp1 t=%0d addr=%h data=%h",
                     rq[0].t - t0, rq[0].data, rq[1].t - t0, rq[1].addr, rq[1].data);
        end
        tick();
        tick();

        // ---- queue full: the IDLE pop at the second edge means five
        // consecutive pushes are needed to fill four entries.
        rq.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'(i % 2), 32'h200 + 32'(i * 16), 128'(i + 1));
            tick();
            if (i == 0) t0 = cyc;
            if (i == 3) check("qf_ready_before_full", 128'(req_ready), 128'(1));
        end
        check("qf_ready_full", 128'(req_ready), 128'(0));
        // Sixth request held until the queue has room; accepted once only.
        drive(1'b0, 1'b1, 1'b1, 32'h250, 128'd6);
        t_acc = -1;
        k = 0;
        while (t_acc < 0 && k < 20) begin
            if (req_ready) begin
                tick();
                t_acc = cyc;
            end else begin
                tick();
            end
            k++;
        end
        idle_bus();
        check("qf_held_accept_edge", 128'(t_acc - t0), 128'(7));
        wait_resps(6, 60);
        for (int i = 0; i < 10; i++) tick();
        check("qf_resp_count", 128'(rq.size()), 128'(6));
        for (int i = 0; i < rq.size() && i < 6; i++) begin
            check($sformatf("qf_addr_%0d", i), 128'(rq[i].addr), 128'(32'h200 + 32'(i * 16)));
            check($sformatf("qf_data_%0d", i), rq[i].data, 128'(i + 1));
            if (i > 0) check($sformatf("qf_spacing_%0d", i), 128'(rq[i].t - rq[i-1].t), 128'(5));
            $display("txn queue_full resp %0d t=%0d id=%0d addr=%h data=%h",
                     i, rq[i].t - t0, rq[i].id, rq[i].addr, rq[i].data);
        end
        check("qf_busy_drained", 128'(busy), 128'(0));

        // ---- reset mid-BUSY discards in-flight and queued work
        rq.delete();
        drive(1'b1, 1'b0, 1'b1, 32'h30, 128'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h100, 128'h0);
        tick();
        idle_bus();
        tick();
        check("mid_busy_before_reset", 128'(busy), 128'(1));
        reset = 1'b0;
        #1;
        check("mid_rst_resp_valid", 128'(resp_valid), 128'(0));
        check("mid_rst_busy",       128'(busy),       128'(0));
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("mid_rst_no_resp", 128'(rq.size()), 128'(0));
        check("mid_rst_ready",   128'(req_ready), 128'(1));
        $display("txn reset_mid_busy responses_after_release=%0d busy=%0b", rq.size(), busy);
        single("rd_line3_after_rst", 1'b1, 1'b0, 1'b1, 32'h30, 128'h0, 1'b1, 32'h30, D_3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
